data_mem_responder: RTL

Data-memory responder for the single-cycle core's load/store path. It accepts one byte/halfword/word request over a valid/ready handshake and applies a programmable number of wait states. It performs the access on an internal word-organised RAM and returns sign- or zero-extended load data, or a store acknowledgement, over a second valid/ready handshake. It is the memory end of the core's MemRead/MemWrite interface and turns that interface into a multi-cycle, stall-capable protocol.

---
 rtl/data_mem_responder.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Load/store responder: accepts one byte/half/word request, waits WAIT_CYCLES,
// accesses an internal word RAM and returns extended load data or a store ack.
module data_mem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_size,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int         DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;
    state_t state_reg, state_next;

    logic [3:0]            cnt_reg;
    logic                  we_reg;
    logic [ADDR_WIDTH-1:0] idx_reg;
    logic [1:0]            lane_reg;
    logic [31:0]           wdata_reg;
    logic [2:0]            size_reg;
    logic                  err_reg;
    logic [31:0]           rd_word_reg;
    logic [31:0]           rsp_rdata_reg;
    logic                  rsp_err_reg;
    logic [31:0]           mem [DEPTH];

    logic                  accept;
    logic                  range_err;
    logic                  req_err;
    logic                  do_write;
    logic [ADDR_WIDTH-1:0] rd_idx;
    logic [3:0]            be;
    logic [31:0]           wlane;
    logic [7:0]            sel_byte;
    logic [15:0]           sel_half;
    logic [31:0]           load_data;

    assign req_ready = (state_reg == S_IDLE) && !reset;
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state_reg == S_RESP);
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;

    // Error classification happens at acceptance so the later stages only carry one bit.
    assign range_err = (req_addr >> (ADDR_WIDTH + 2)) != 32'd0;

    always_comb begin
        req_err = range_err;
        case (req_size)
            3'b000:  req_err = range_err;
            3'b001:  if (req_addr[0]) req_err = 1'b1;
            3'b010:  if (req_addr[1:0] != 2'b00) req_err = 1'b1;
            3'b100:  if (req_we) req_err = 1'b1;
            3'b101:  if (req_we || req_addr[0]) req_err = 1'b1;
            default: req_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (accept) state_next = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
            S_WAIT:   if (cnt_reg <= 4'd1) state_next = S_ACCESS;
            S_ACCESS: state_next = S_RESP;
            S_RESP:   if (rsp_ready) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg <= 4'd0;
        end else if (accept) begin
            cnt_reg <= WAIT_INIT;
        end else if (state_reg == S_WAIT && cnt_reg > 4'd1) begin
            cnt_reg <= cnt_reg - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            we_reg    <= req_we;
            idx_reg   <= req_addr[ADDR_WIDTH+1:2];
            lane_reg  <= req_addr[1:0];
            wdata_reg <= req_wdata;
            size_reg  <= req_size;
            err_reg   <= req_err;
        end
    end

    // Only legal store sizes (b/h/w) ever reach a write, so size_reg[1:0] selects the lane pattern.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign be[gi] = (size_reg[1:0] == 2'b00) ? (lane_reg == LANE) :
                            (size_reg[1:0] == 2'b01) ? (lane_reg[1] == LANE[1]) : 1'b1;
            assign wlane[8*gi +: 8] = (size_reg[1:0] == 2'b00) ? wdata_reg[7:0] :
                                      (size_reg[1:0] == 2'b01) ? wdata_reg[8*(gi%2) +: 8] :
                                                                 wdata_reg[8*gi +: 8];
        end
    endgenerate

    assign do_write = (state_reg == S_ACCESS) && we_reg && !err_reg && !reset;
    // Read uses the incoming address while idle so the word is ready by the ACCESS cycle even with no wait states.
    assign rd_idx   = (state_reg == S_IDLE) ? req_addr[ADDR_WIDTH+1:2] : idx_reg;

    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx_reg][8*b +: 8] <= wlane[8*b +: 8];
            end
        end
        rd_word_reg <= mem[rd_idx];
    end

    assign sel_byte = rd_word_reg[{lane_reg, 3'b000} +: 8];
    assign sel_half = lane_reg[1] ? rd_word_reg[31:16] : rd_word_reg[15:0];

    always_comb begin
        load_data = rd_word_reg;
        case (size_reg)
            3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
            3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
            3'b100:  load_data = {24'd0, sel_byte};
            3'b101:  load_data = {16'd0, sel_half};
            default: load_data = rd_word_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_rdata_reg <= 32'd0;
            rsp_err_reg   <= 1'b0;
        end else if (state_reg == S_ACCESS) begin
            rsp_err_reg   <= err_reg;
            rsp_rdata_reg <= (we_reg || err_reg) ? 32'd0 : load_data;
        end else if (state_reg == S_RESP && rsp_ready) begin
            rsp_rdata_reg <= 32'd0;
            rsp_err_reg   <= 1'b0;
        end
    end
endmodule
